// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: owns the PC, drives the imem req/ready
//            handshake and produces the registered PC/instruction pair for IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] PC_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_inst_out;
    logic        r_valid_out;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic        r_hold_valid;
    logic [31:0] w_pc_next;

    assign w_pc_next   = r_pc + 32'd4;
    assign imem_req_o  = (r_state == c_FETCH);
    assign imem_addr_o = r_pc;
    assign PC_o        = r_pc_out;
    assign inst_o      = r_inst_out;
    assign valid_o     = r_valid_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_IDLE;
            r_pc         <= RESET_PC;
            r_pc_out     <= RESET_PC;
            r_inst_out   <= NOP_INST;
            r_valid_out  <= 1'b0;
            r_hold_pc    <= RESET_PC;
            r_hold_inst  <= NOP_INST;
            r_hold_valid <= 1'b0;
        end else if (redirect_i) begin
            // Any response arriving this cycle belongs to the wrong path.
            r_state      <= c_FETCH;
            r_pc         <= {redirect_pc_i[31:2], 2'b00};
            r_inst_out   <= NOP_INST;
            r_valid_out  <= 1'b0;
            r_hold_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state <= c_FETCH;
                end
                c_FETCH: begin
                    if (imem_ready_i) begin
                        r_pc <= w_pc_next;
                        if (stall_i) begin
                            r_hold_pc    <= r_pc;
                            r_hold_inst  <= imem_data_i;
                            r_hold_valid <= 1'b1;
                            r_state      <= c_HOLD;
                        end else begin
                            r_pc_out    <= r_pc;
                            r_inst_out  <= imem_data_i;
                            r_valid_out <= 1'b1;
                        end
                    end else if (!stall_i) begin
                        r_inst_out  <= NOP_INST;
                        r_valid_out <= 1'b0;
                    end
                end
                c_HOLD: begin
                    // Drain the buffer; the fetch at r_pc starts in the same cycle.
                    if (!stall_i) begin
                        r_pc_out     <= r_hold_pc;
                        r_inst_out   <= r_hold_inst;
                        r_valid_out  <= 1'b1;
                        r_hold_valid <= 1'b0;
                        r_state      <= c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic        req_a, req_b;
    logic [31:0] addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [31:0] pc_a, pc_b;
    logic [31:0] inst_a, inst_b;
    logic        valid_a, valid_b;

    int n_vec = 0;
    int n_err = 0;

    // Memory model: each word is its address xor a fixed pattern.
    assign data_a = addr_a ^ 32'hA5A5_0000;
    assign data_b = addr_b ^ 32'hA5A5_0000;

    fetch_unit dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req_a), .imem_addr_o(addr_a),
        .imem_ready_i(ready), .imem_data_i(data_a), .PC_o(pc_a), .inst_o(inst_a),
        .valid_o(valid_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req_b), .imem_addr_o(addr_b),
        .imem_ready_i(ready), .imem_data_i(data_b), .PC_o(pc_b), .inst_o(inst_b),
        .valid_o(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ready = 1'b1;
        tick(); tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a} !== {1'b0, 32'h0, 32'h13}) begin
            n_err++;
            $display("FAIL reset_out: got v=%b pc=%h inst=%h want v=0 pc=0 inst=00000013", valid_a, pc_a, inst_a);
        end
        n_vec++;
        if ({req_a, addr_a} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_req: got req=%b addr=%h want req=0 addr=0", req_a, addr_a);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if ({valid_a, req_a, addr_a} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL first_edge: got v=%b req=%b addr=%h want v=0 req=1 addr=0", valid_a, req_a, addr_a);
        end
    endtask

    task automatic test_run();
        logic [31:0] exp_pc;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = 32'(i * 4);
            n_vec++;
            if ({valid_a, pc_a, inst_a} !== {1'b1, exp_pc, exp_pc ^ 32'hA5A5_0000}) begin
                n_err++;
                $display("FAIL run_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, valid_a, pc_a, inst_a, exp_pc, exp_pc ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_wait_states();
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({valid_a, pc_a, inst_a, req_a, addr_a} !== {1'b0, 32'h4, 32'h13, 1'b1, 32'h8}) begin
                n_err++;
                $display("FAIL wait_%0d: got v=%b pc=%h inst=%h req=%b addr=%h want v=0 pc=4 inst=13 req=1 addr=8",
                         i, valid_a, pc_a, inst_a, req_a, addr_a);
            end
        end
        ready = 1'b1;
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a, addr_a} !== {1'b1, 32'h8, 32'hA5A5_0008, 32'hC}) begin
            n_err++;
            $display("FAIL wait_done: got v=%b pc=%h inst=%h addr=%h want v=1 pc=8 inst=a5a50008 addr=c",
                     valid_a, pc_a, inst_a, addr_a);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({valid_a, pc_a, inst_a, req_a, addr_a} !== {1'b1, 32'h8, 32'hA5A5_0008, 1'b0, 32'h10}) begin
                n_err++;
                $display("FAIL stall_%0d: got v=%b pc=%h inst=%h req=%b addr=%h want v=1 pc=8 inst=a5a50008 req=0 addr=10",
                         i, valid_a, pc_a, inst_a, req_a, addr_a);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a, req_a, addr_a} !== {1'b1, 32'hC, 32'hA5A5_000C, 1'b1, 32'h10}) begin
            n_err++;
            $display("FAIL stall_drain: got v=%b pc=%h inst=%h req=%b addr=%h want v=1 pc=c inst=a5a5000c req=1 addr=10",
                     valid_a, pc_a, inst_a, req_a, addr_a);
        end
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a} !== {1'b1, 32'h10, 32'hA5A5_0010}) begin
            n_err++;
            $display("FAIL stall_next: got v=%b pc=%h inst=%h want v=1 pc=10 inst=a5a50010", valid_a, pc_a, inst_a);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1;
        tick();
        n_vec++;
        if ({req_a, addr_a} !== {1'b0, 32'h18}) begin
            n_err++;
            $display("FAIL redir_hold: got req=%b addr=%h want req=0 addr=18", req_a, addr_a);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        n_vec++;
        if ({valid_a, inst_a, pc_a, req_a, addr_a} !== {1'b0, 32'h13, 32'h10, 1'b1, 32'h100}) begin
            n_err++;
            $display("FAIL redir_flush: got v=%b inst=%h pc=%h req=%b addr=%h want v=0 inst=13 pc=10 req=1 addr=100",
                     valid_a, inst_a, pc_a, req_a, addr_a);
        end
        redirect = 1'b0; stall = 1'b0;
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin
            n_err++;
            $display("FAIL redir_target: got v=%b pc=%h inst=%h want v=1 pc=100 inst=a5a50100", valid_a, pc_a, inst_a);
        end
        // Redirect while a response is being accepted: that response is dropped.
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        n_vec++;
        if ({valid_a, pc_a, addr_a} !== {1'b0, 32'h100, 32'h200}) begin
            n_err++;
            $display("FAIL redir_fetch: got v=%b pc=%h addr=%h want v=0 pc=100 addr=200", valid_a, pc_a, addr_a);
        end
        redirect = 1'b0;
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a} !== {1'b1, 32'h200, 32'hA5A5_0200}) begin
            n_err++;
            $display("FAIL redir_fetch_tgt: got v=%b pc=%h inst=%h want v=1 pc=200 inst=a5a50200", valid_a, pc_a, inst_a);
        end
    endtask

    task automatic test_reset_in_hold();
        stall = 1'b1;
        tick();
        n_vec++;
        if ({req_a, addr_a} !== {1'b0, 32'h208}) begin
            n_err++;
            $display("FAIL rsthold_enter: got req=%b addr=%h want req=0 addr=208", req_a, addr_a);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        n_vec++;
        if ({valid_a, pc_a, inst_a, req_a, addr_a} !== {1'b0, 32'h0, 32'h13, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL rsthold_reset: got v=%b pc=%h inst=%h req=%b addr=%h want v=0 pc=0 inst=13 req=0 addr=0",
                     valid_a, pc_a, inst_a, req_a, addr_a);
        end
        tick();
        n_vec++;
        if ({valid_a, req_a, addr_a} !== {1'b0, 1'b1, 32'h0}) begin
            n_err++;
            $display("FAIL rsthold_restart: got v=%b req=%b addr=%h want v=0 req=1 addr=0", valid_a, req_a, addr_a);
        end
        tick();
        n_vec++;
        if ({valid_a, pc_a, inst_a} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin
            n_err++;
            $display("FAIL rsthold_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=a5a50000", valid_a, pc_a, inst_a);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; ready = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if ({valid_b, pc_b, addr_b} !== {1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8}) begin
            n_err++;
            $display("FAIL wrap_reset: got v=%b pc=%h addr=%h want v=0 pc=fffffff8 addr=fffffff8", valid_b, pc_b, addr_b);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({valid_b, pc_b, inst_b} !== {1'b1, exp_pc[i], exp_pc[i] ^ 32'hA5A5_0000}) begin
                n_err++;
                $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, valid_b, pc_b, inst_b, exp_pc[i], exp_pc[i] ^ 32'hA5A5_0000);
            end
        end
        n_vec++;
        if (addr_b !== 32'h4) begin
            n_err++;
            $display("FAIL wrap_addr: got addr=%h want addr=00000004", addr_b);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_wait_states();
        test_stall();
        test_redirect();
        test_reset_in_hold();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register.
- Owns the program counter and issues requests to instruction memory using a req/ready handshake.
- Handles stalls from the hazard unit with a one-entry hold buffer.
- Handles branch/jump redirects from later stages by inserting NOP bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when valid_o=0.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  synchronous active-high reset.
- stall_i  input  1  hazard unit: hold outputs, do not advance downstream.
- redirect_i  input  1  branch/jump taken; flush and reload PC.
- redirect_pc_i  input  32  redirect target.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address; always equals internal pc_reg.
- imem_ready_i  input  1  memory accepted the request; imem_data_i is valid in this cycle.
- imem_data_i  input  32  fetched instruction word.
- PC_o  output  32  PC of inst_o, to IF/ID PC_i.
- inst_o  output  32  instruction, to IF/ID inst_i.
- valid_o  output  1  inst_o is a real instruction, not a bubble.

Behaviour:
- State machine: IDLE, FETCH, HOLD.
- Outputs: PC_o, inst_o and valid_o are registered. imem_req_o = (state==FETCH). imem_addr_o = pc_reg (combinational).
- Reset (rst_i=1 at an edge, highest priority):
  - pc_reg=RESET_PC, PC_o=RESET_PC, inst_o=NOP_INST, valid_o=0.
  - Hold buffer cleared, state=IDLE.
  - Reset mid-fetch or in HOLD discards all in-flight state.
- IDLE: next cycle goes to FETCH unconditionally, unless redirect_i is high (see redirect rule).
- Redirect (redirect_i=1, priority over stall_i):
  - pc_reg <= {redirect_pc_i[31:2],2'b00}.
  - valid_o <= 0, inst_o <= NOP_INST, PC_o holds.
  - Hold buffer invalidated; state <= FETCH.
  - A response arriving in the same cycle (imem_ready_i=1) is discarded.
- Stall (stall_i=1, no redirect): output registers hold.
  - FETCH with imem_ready_i=1: buffer {pc_reg, imem_data_i}, pc_reg <= pc_reg+4, state <= HOLD.
  - FETCH with imem_ready_i=0: remain in FETCH with the request held.
  - HOLD: remain in HOLD; no request is issued.
- Run (stall_i=0, no redirect):
  - FETCH with imem_ready_i=1: PC_o <= pc_reg, inst_o <= imem_data_i, valid_o <= 1, pc_reg <= pc_reg+4.
  - FETCH with imem_ready_i=0: valid_o <= 0, inst_o <= NOP_INST, PC_o holds (wait-state bubble).
  - HOLD: outputs load from the buffer, valid_o <= 1, state <= FETCH. The fetch at the new pc_reg starts in the same cycle.
- Latency: first valid_o=1 no earlier than the 2nd rising edge after reset deasserts, given zero-wait memory.
- Throughput: 1 instruction/cycle with imem_ready_i held high.
- Arithmetic: pc_reg+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect target: bits [1:0] are forced to 0.
- Request stability: imem_addr_o changes only after an accepted request (ready=1), a redirect, or a reset.
- Invariants:
  - No instruction is dropped or duplicated across any stall pattern.
  - No instruction from the wrong path reaches valid_o=1 after a redirect.

Test Plan:
- Reset then zero-wait memory returning data=addr^32'hA5A5_0000, no stall:
  - PC_o sequence 0,4,8,C with matching inst_o.
  - valid_o=1 from the 2nd edge onward.
- Memory inserts 2 wait cycles at addr 8:
  - Two bubbles with valid_o=0 and inst_o=32'h13, PC_o held at 4.
  - Then PC_o=8; imem_addr_o stays 8 throughout.
- stall_i high for 3 cycles while the fetch of addr C completes:
  - Outputs hold at PC_o=8.
  - Enters HOLD with imem_req_o=0, then outputs C, then 10; no loss or duplication.
- redirect_i with redirect_pc_i=32'h0000_0103 while in HOLD and stall_i=1:
  - Next cycle valid_o=0, buffer dropped, imem_addr_o=32'h100.
  - Next valid output has PC_o=32'h100.
- RESET_PC=32'hFFFF_FFF8, no stall: PC_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_i asserted for 1 cycle while in HOLD:
  - Next cycle state=IDLE, valid_o=0, PC_o=RESET_PC.
  - Fetch restarts at RESET_PC.
